// File: rtl/multi_sensor_alarm_pkg.sv
// ---------------------------------------------------------------------------
// multi_sensor_alarm_pkg
// Shared definitions for the multi-channel sensor alarm controller.
//   - alarmState_e : controller states (IDLE, QUALIFY, ALARM, COOLDOWN)
//   - COUNT_W      : width of the alarm event counter
//   - satIncrement : increments an event count, sticking at its maximum
// ---------------------------------------------------------------------------
package multi_sensor_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    ALARM    = 2'd2,
    COOLDOWN = 2'd3
  } alarmState_e;

  localparam int COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // The event counter must never wrap back to zero after many alarms,
  // so it holds at its all-ones value once reached.
  function automatic logic [COUNT_W-1:0] satIncrement(input logic [COUNT_W-1:0] value);
    return (value == COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/alarm_prio_enc.sv
// ---------------------------------------------------------------------------
// alarm_prio_enc
// Lowest-index priority encoder used to pick the winning sensor channel.
// Ports:
//   req_i   [WIDTH-1:0] : request bits (raw sensor levels)
//   valid_o             : high when any request bit is set
//   idx_o   [IDW-1:0]   : index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module alarm_prio_enc
  import multi_sensor_alarm_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDW-1:0]   idx_o
);

  // Scan from the top bit downwards so that the last match written, and
  // therefore the surviving value, is the lowest asserted index.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/multi_sensor_alarm.sv
// ---------------------------------------------------------------------------
// multi_sensor_alarm
// N-channel sensor alarm controller. The lowest-index active sensor must win
// for DEBOUNCE_LEN consecutive cycles before an alarm is raised. The alarm
// drives a one-hot buzzer either for ALARM_LEN cycles (timed) or until ack
// (latched), and is followed by a COOLDOWN_LEN cycle window in which sensors
// are ignored.
// Ports:
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   sensor_i       : raw sensor levels, synchronous to clk
//   enable_i       : arm; low returns the controller to IDLE
//   latch_mode_i   : 0 = timed alarm, 1 = held until ack (sampled on ALARM entry)
//   ack_i          : acknowledge, ends an alarm in either mode
//   buzzer_o       : one-hot buzzer drive, zero outside ALARM
//   alarm_active_o : high while in ALARM
//   alarm_id_o     : index of the most recent alarm (sticky)
//   alarm_count_o  : alarms raised since reset, saturating at 255
// ---------------------------------------------------------------------------
module multi_sensor_alarm
  import multi_sensor_alarm_pkg::*;
#(
  parameter int NUM_SENSORS  = 3,
  parameter int DEBOUNCE_LEN = 7,
  parameter int ALARM_LEN    = 31,
  parameter int COOLDOWN_LEN = 8,
  parameter int IDW          = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] sensor_i,
  input  logic                   enable_i,
  input  logic                   latch_mode_i,
  input  logic                   ack_i,
  output logic [NUM_SENSORS-1:0] buzzer_o,
  output logic                   alarm_active_o,
  output logic [IDW-1:0]         alarm_id_o,
  output logic [COUNT_W-1:0]     alarm_count_o
);

  localparam int QUAL_W  = $clog2(DEBOUNCE_LEN + 1);
  localparam int ALARM_W = $clog2(ALARM_LEN + 1);
  localparam int CD_W    = $clog2(COOLDOWN_LEN + 1);

  localparam logic [QUAL_W-1:0]  QUAL_LAST  = QUAL_W'(DEBOUNCE_LEN - 1);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_LEN - 1);
  localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COOLDOWN_LEN - 1);

  alarmState_e          state_q,      state_d;
  logic [IDW-1:0]       cand_q,       cand_d;
  logic [QUAL_W-1:0]    qualCnt_q,    qualCnt_d;
  logic [ALARM_W-1:0]   alarmCnt_q,   alarmCnt_d;
  logic [CD_W-1:0]      cdCnt_q,      cdCnt_d;
  logic                 latch_q,      latch_d;
  logic [NUM_SENSORS-1:0] buzzer_q,   buzzer_d;
  logic                 active_q,     active_d;
  logic [IDW-1:0]       alarmId_q,    alarmId_d;
  logic [COUNT_W-1:0]   alarmCount_q, alarmCount_d;

  logic                 candValid;
  logic [IDW-1:0]       candIdx;
  logic                 alarmEntry;

  alarm_prio_enc #(
    .WIDTH (NUM_SENSORS),
    .IDW   (IDW)
  ) u_prio_enc (
    .req_i   (sensor_i),
    .valid_o (candValid),
    .idx_o   (candIdx)
  );

  // State register plus every counter and registered output. Reset clears
  // the buzzer without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      qualCnt_q    <= '0;
      alarmCnt_q   <= '0;
      cdCnt_q      <= '0;
      latch_q      <= 1'b0;
      buzzer_q     <= '0;
      active_q     <= 1'b0;
      alarmId_q    <= '0;
      alarmCount_q <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      qualCnt_q    <= qualCnt_d;
      alarmCnt_q   <= alarmCnt_d;
      cdCnt_q      <= cdCnt_d;
      latch_q      <= latch_d;
      buzzer_q     <= buzzer_d;
      active_q     <= active_d;
      alarmId_q    <= alarmId_d;
      alarmCount_q <= alarmCount_d;
    end
  end

  // Next-state logic. Sensors only matter in IDLE and QUALIFY; a change of
  // winning channel during qualification restarts the debounce count on the
  // new channel. Every counter stops at its terminal compare, so none wraps.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    qualCnt_d  = qualCnt_q;
    alarmCnt_d = alarmCnt_q;
    cdCnt_d    = cdCnt_q;
    latch_d    = latch_q;

    unique case (state_q)
      IDLE: begin
        if (enable_i && candValid) begin
          state_d   = QUALIFY;
          cand_d    = candIdx;
          qualCnt_d = QUAL_W'(1);
        end
      end

      QUALIFY: begin
        if (!enable_i || !candValid) begin
          state_d   = IDLE;
          qualCnt_d = '0;
        end else if (candIdx != cand_q) begin
          cand_d    = candIdx;
          qualCnt_d = QUAL_W'(1);
        end else if (qualCnt_q == QUAL_LAST) begin
          state_d    = ALARM;
          qualCnt_d  = '0;
          latch_d    = latch_mode_i;
          alarmCnt_d = '0;
        end else begin
          qualCnt_d = qualCnt_q + QUAL_W'(1);
        end
      end

      ALARM: begin
        if (!enable_i) begin
          state_d = IDLE;
          cdCnt_d = '0;
        end else if (ack_i || (!latch_q && (alarmCnt_q == ALARM_LAST))) begin
          state_d = COOLDOWN;
          cdCnt_d = '0;
        end else if (!latch_q) begin
          alarmCnt_d = alarmCnt_q + ALARM_W'(1);
        end
      end

      COOLDOWN: begin
        if (!enable_i || (cdCnt_q == CD_LAST)) begin
          state_d = IDLE;
        end else begin
          cdCnt_d = cdCnt_q + CD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic, computed from the upcoming state so that every output is
  // a plain register. The alarm id and event count only change on the cycle
  // that enters ALARM; cand_q is frozen for the whole alarm.
  always_comb begin
    alarmEntry   = (state_q != ALARM) && (state_d == ALARM);
    active_d     = (state_d == ALARM);
    buzzer_d     = '0;
    alarmId_d    = alarmId_q;
    alarmCount_d = alarmCount_q;

    if (state_d == ALARM) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        buzzer_d[i] = (cand_q == IDW'(i));
      end
    end

    if (alarmEntry) begin
      alarmId_d    = cand_q;
      alarmCount_d = satIncrement(alarmCount_q);
    end
  end

  assign buzzer_o       = buzzer_q;
  assign alarm_active_o = active_q;
  assign alarm_id_o     = alarmId_q;
  assign alarm_count_o  = alarmCount_q;

endmodule

// File: tb/tb_multi_sensor_alarm.sv
// ---------------------------------------------------------------------------
// tb_multi_sensor_alarm
// Directed bench for multi_sensor_alarm with default parameters. Each scenario
// queues the alarm start/end events it expects (cycle, buzzer, id, count);
// an independent monitor pops and compares whenever alarm_active_o toggles.
// ---------------------------------------------------------------------------
module tb_multi_sensor_alarm;

  localparam int N     = 3;
  localparam int IDW   = 2;
  localparam int DEB   = 7;
  localparam int ALEN  = 31;
  localparam int CLEN  = 8;
  localparam int PERIOD = DEB + ALEN + CLEN;

  typedef struct {
    bit           isStart;
    int           cyc;
    logic [N-1:0] buzz;
    logic [IDW-1:0] id;
    logic [7:0]   count;
  } alarmEvent_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   sensor;
  logic           enable;
  logic           latchMode;
  logic           ack;
  logic [N-1:0]   buzzer;
  logic           alarmActive;
  logic [IDW-1:0] alarmId;
  logic [7:0]     alarmCount;

  alarmEvent_t    expQ[$];
  alarmEvent_t    expEvt;
  int             cycle = 0;
  int             assertCount = 0;
  int             failCount = 0;
  logic           prevActive = 1'b0;
  bit             evtOk;

  multi_sensor_alarm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensor_i       (sensor),
    .enable_i       (enable),
    .latch_mode_i   (latchMode),
    .ack_i          (ack),
    .buzzer_o       (buzzer),
    .alarm_active_o (alarmActive),
    .alarm_id_o     (alarmId),
    .alarm_count_o  (alarmCount)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far, used to time events.
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: on the falling edge, check buzzer/active agreement, and on every
  // change of alarm_active_o pop the next expected event and compare it.
  always @(negedge clk) begin
    assertCount++;
    if ((buzzer != '0) !== alarmActive) begin
      failCount++;
      $display("[TB] FAIL buzzerConsistency: cycle %0d buzzer=%b active=%b, required buzzer nonzero exactly when active",
               cycle, buzzer, alarmActive);
    end
    if (alarmActive !== prevActive) begin
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpectedEvent: cycle %0d active went to %b, required no event", cycle, alarmActive);
      end else begin
        expEvt = expQ.pop_front();
        if (alarmActive)
          evtOk = expEvt.isStart && (expEvt.cyc == cycle) && (buzzer === expEvt.buzz)
                  && (alarmId === expEvt.id) && (alarmCount === expEvt.count);
        else
          evtOk = !expEvt.isStart && (expEvt.cyc == cycle) && (buzzer === '0);
        if (!evtOk) begin
          failCount++;
          $display("[TB] FAIL alarmEvent: got active=%b cycle=%0d buzzer=%b id=%0d count=%0d, required start=%0b cycle=%0d buzzer=%b id=%0d count=%0d",
                   alarmActive, cycle, buzzer, alarmId, alarmCount,
                   expEvt.isStart, expEvt.cyc, expEvt.isStart ? expEvt.buzz : 3'b000, expEvt.id, expEvt.count);
        end
      end
      prevActive = alarmActive;
    end
  end

  task automatic applyStimulus(input logic [N-1:0] s, input logic en, input logic lm, input logic ak);
    sensor    = s;
    enable    = en;
    latchMode = lm;
    ack       = ak;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eBuzz, input logic eActive,
                             input logic [IDW-1:0] eId, input logic [7:0] eCount);
    assertCount++;
    if ({buzzer, alarmActive, alarmId, alarmCount} !== {eBuzz, eActive, eId, eCount}) begin
      failCount++;
      $display("[TB] FAIL %s: got buzzer=%b active=%b id=%0d count=%0d, required buzzer=%b active=%b id=%0d count=%0d",
               name, buzzer, alarmActive, alarmId, alarmCount, eBuzz, eActive, eId, eCount);
    end
  endtask

  task automatic expectStart(input int cyc, input logic [N-1:0] b, input logic [IDW-1:0] id, input logic [7:0] cnt);
    alarmEvent_t e;
    e.isStart = 1'b1;
    e.cyc     = cyc;
    e.buzz    = b;
    e.id      = id;
    e.count   = cnt;
    expQ.push_back(e);
  endtask

  task automatic expectEnd(input int cyc);
    alarmEvent_t e;
    e.isStart = 1'b0;
    e.cyc     = cyc;
    e.buzz    = '0;
    e.id      = '0;
    e.count   = '0;
    expQ.push_back(e);
  endtask

  // Directed scenarios; all event cycles are relative to the edge just passed.
  initial begin
    int c;
    logic [7:0] cnt;

    rst_n = 1'b1;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2 checkOutput("resetState", 3'b000, 1'b0, 2'd0, 8'd0);
    #10 rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(2);

    // Short pulse on sensor 1: five qualifying cycles are not enough.
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
    waitCycles(5);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("shortPulseNoAlarm", 3'b000, 1'b0, 2'd0, 8'd0);

    // Sensor 0 held, timed mode: two alarms separated by cooldown + requalify.
    c = cycle;
    expectStart(c + DEB, 3'b001, 2'd0, 8'd1);
    expectEnd(c + DEB + ALEN);
    expectStart(c + DEB + PERIOD, 3'b001, 2'd0, 8'd2);
    expectEnd(c + DEB + PERIOD + ALEN);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    waitCycles(DEB - 1);
    checkOutput("debounceNotYet", 3'b000, 1'b0, 2'd0, 8'd0);
    waitCycles(14);
    checkOutput("timedMidAlarm", 3'b001, 1'b1, 2'd0, 8'd1);
    waitCycles(40);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(35);
    checkOutput("afterTimedPair", 3'b000, 1'b0, 2'd0, 8'd2);

    // Sensor 2 for four cycles, then sensor 1 joins and wins: count restarts.
    c = cycle;
    applyStimulus(3'b100, 1'b1, 1'b0, 1'b0);
    waitCycles(4);
    expectStart(c + 4 + DEB, 3'b010, 2'd1, 8'd3);
    expectEnd(c + 4 + DEB + ALEN);
    applyStimulus(3'b110, 1'b1, 1'b0, 1'b0);
    waitCycles(8);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(45);
    checkOutput("stickyIdAfterSwitch", 3'b000, 1'b0, 2'd1, 8'd3);

    // Latched alarm held well past ALARM_LEN, released by ack; a mid-alarm
    // change of latch_mode_i must not matter.
    c = cycle;
    expectStart(c + DEB, 3'b001, 2'd0, 8'd4);
    applyStimulus(3'b001, 1'b1, 1'b1, 1'b0);
    waitCycles(10);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(110);
    checkOutput("latchHeld", 3'b001, 1'b1, 2'd0, 8'd4);
    expectEnd(c + 121);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    checkOutput("ackReleases", 3'b000, 1'b0, 2'd0, 8'd4);
    // Sensor stays high: cooldown of 8 cycles, then a full requalification.
    expectStart(c + 121 + CLEN + DEB, 3'b001, 2'd0, 8'd5);
    waitCycles(2);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    waitCycles(14);

    // Alarm in progress (timed); dropping enable ends it on the next edge.
    expectEnd(c + 141);
    waitCycles(2);
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("enableDrop", 3'b000, 1'b0, 2'd0, 8'd5);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(1);

    // Reset pulse mid-alarm clears outputs with no clock edge.
    c = cycle;
    expectStart(c + DEB, 3'b010, 2'd1, 8'd6);
    expectEnd(c + 10);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
    waitCycles(9);
    checkOutput("beforeAsyncReset", 3'b010, 1'b1, 2'd1, 8'd6);
    waitCycles(1);
    #1 rst_n = 1'b0;
    #1 checkOutput("asyncReset", 3'b000, 1'b0, 2'd0, 8'd0);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);

    // 256 back-to-back timed alarms: the event count saturates at 255.
    c = cycle;
    for (int i = 0; i < 256; i++) begin
      cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      expectStart(c + DEB + PERIOD * i, 3'b001, 2'd0, cnt);
      expectEnd(c + DEB + PERIOD * i + ALEN);
    end
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    waitCycles(DEB + PERIOD * 255 + 1);
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    waitCycles(45);
    checkOutput("countSaturated", 3'b000, 1'b0, 2'd0, 8'd255);

    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL pendingEvents: got %0d events never observed, required 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
